axi_lite_hash_slave: RTL

- AXI4-Lite slave front-end for the multi-table hash unit; successor of the fixed 2-bit AXI wrapper.
- Parametrised data and address widths, full byte-strobe support, independent AW/W acceptance, and SLVERR signalling.
- Maps KEY, DATA, CMD, STATUS and RESULT registers onto a valid/ready command/response port to the hash table core.
- Sits between the system interconnect and the hash table top.

---
 rtl/axi_lite_hash_slave_if.sv | 42 ++++
 rtl/axi_lite_hash_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_hash_slave_if.sv
// AXI4-Lite bus bundle between the system interconnect and the hash slave front-end.
// The master modport is the interconnect side; the slave modport is the register block.
interface axi_lite_hash_slave_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 5
);
    logic                          AWVALID;
    logic [AXI_ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                    AWPROT;
    logic                          AWREADY;
    logic                          WVALID;
    logic [AXI_DATA_WIDTH-1:0]     WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   WSTRB;
    logic                          WREADY;
    logic                          BVALID;
    logic [1:0]                    BRESP;
    logic                          BREADY;
    logic                          ARVALID;
    logic [AXI_ADDR_WIDTH-1:0]     ARADDR;
    logic [2:0]                    ARPROT;
    logic                          ARREADY;
    logic                          RVALID;
    logic [AXI_DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                    RRESP;
    logic                          RREADY;

    modport master (
        output AWVALID, AWADDR, AWPROT, input AWREADY,
        output WVALID, WDATA, WSTRB, input WREADY,
        input BVALID, BRESP, output BREADY,
        output ARVALID, ARADDR, ARPROT, input ARREADY,
        input RVALID, RDATA, RRESP, output RREADY
    );

    modport slave (
        input AWVALID, AWADDR, AWPROT, output AWREADY,
        input WVALID, WDATA, WSTRB, output WREADY,
        output BVALID, BRESP, input BREADY,
        input ARVALID, ARADDR, ARPROT, output ARREADY,
        output RVALID, RDATA, RRESP, input RREADY
    );
endinterface

// File: rtl/axi_lite_hash_slave.sv
// AXI4-Lite register front-end for the hash table core: KEY/DATA/CMD/STATUS/RESULT
// registers mapped onto a valid/ready command port and a single-beat response port.
module axi_lite_hash_slave #(
    parameter int KEY_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_lite_hash_slave_if.slave   s_axi,
    output logic                   tbl_req_valid,
    input  logic                   tbl_req_ready,
    output logic [1:0]             tbl_req_op,
    output logic [KEY_WIDTH-1:0]   tbl_req_key,
    output logic [DATA_WIDTH-1:0]  tbl_req_data,
    input  logic                   tbl_rsp_valid,
    input  logic                   tbl_rsp_hit,
    input  logic                   tbl_rsp_err,
    input  logic [DATA_WIDTH-1:0]  tbl_rsp_data
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] OP_LOOKUP   = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    state_t state_q, state_d;

    logic                       ready_en;
    logic                       aw_full, w_full;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr;
    logic [AXI_DATA_WIDTH-1:0]  w_data;
    logic [STRB_WIDTH-1:0]      w_strb;
    logic [AXI_DATA_WIDTH-1:0]  key_reg, data_reg;
    logic [DATA_WIDTH-1:0]      result_reg;
    logic                       done_q, hit_q, err_q;
    logic                       bvalid_q, rvalid_q;
    logic [1:0]                 bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;

    logic                       busy, commit, key_we, data_we, cmd_launch;
    logic [1:0]                 wr_resp;
    logic                       aw_hs, w_hs, ar_hs, req_hs, rsp_take;
    logic [AXI_DATA_WIDTH-1:0]  status_word, rd_data_d;
    logic [1:0]                 rd_resp_d;
    logic                       unused_bits;

    // Ready outputs stay low during reset and for the first edge after release.
    assign s_axi.AWREADY = ready_en & ~aw_full;
    assign s_axi.WREADY  = ready_en & ~w_full;
    assign s_axi.ARREADY = ready_en & ~rvalid_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RDATA   = rdata_q;

    assign aw_hs    = s_axi.AWVALID & s_axi.AWREADY;
    assign w_hs     = s_axi.WVALID & s_axi.WREADY;
    assign ar_hs    = s_axi.ARVALID & s_axi.ARREADY;
    assign busy     = (state_q != ST_IDLE);
    assign commit   = aw_full & w_full & ~bvalid_q;
    assign req_hs   = (state_q == ST_REQ) & tbl_req_ready;
    assign rsp_take = (state_q == ST_WAIT) & tbl_rsp_valid;
    assign tbl_req_valid = (state_q == ST_REQ);
    assign status_word   = AXI_DATA_WIDTH'({err_q, hit_q, done_q, busy});
    assign unused_bits   = ^{s_axi.AWPROT, s_axi.ARPROT, aw_addr, s_axi.ARADDR};

    function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0]     strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Decode the committing write; a busy unit rejects any CMD write outright.
    always_comb begin
        wr_resp    = RESP_OKAY;
        key_we     = 1'b0;
        data_we    = 1'b0;
        cmd_launch = 1'b0;
        if (commit) begin
            case (aw_addr[4:2])
                3'd0: key_we = 1'b1;
                3'd1: data_we = 1'b1;
                3'd2: begin
                    if (busy) wr_resp = RESP_SLVERR;
                    else if (w_strb[0] && (w_data[1:0] != 2'd0)) cmd_launch = 1'b1;
                end
                default: wr_resp = RESP_SLVERR;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        case (s_axi.ARADDR[4:2])
            3'd0: rd_data_d = key_reg;
            3'd1: rd_data_d = data_reg;
            3'd2: rd_data_d = '0;
            3'd3: rd_data_d = status_word;
            3'd4: rd_data_d = AXI_DATA_WIDTH'(result_reg);
            default: rd_resp_d = RESP_SLVERR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_launch) state_d = ST_REQ;
            ST_REQ:  if (tbl_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (tbl_rsp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // AW/W holding registers and the B channel; a new commit waits for the B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.AWADDR;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi.WDATA;
                w_strb <= s_axi.WSTRB;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (s_axi.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // Register file, request snapshot and status flags owned by the command sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg      <= '0;
            data_reg     <= '0;
            result_reg   <= '0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            tbl_req_op   <= 2'd0;
            tbl_req_key  <= '0;
            tbl_req_data <= '0;
        end else begin
            if (key_we)  key_reg  <= merge_bytes(key_reg, w_data, w_strb);
            if (data_we) data_reg <= merge_bytes(data_reg, w_data, w_strb);
            if (cmd_launch) begin
                tbl_req_op   <= w_data[1:0];
                tbl_req_key  <= key_reg[KEY_WIDTH-1:0];
                tbl_req_data <= data_reg[DATA_WIDTH-1:0];
                done_q       <= 1'b0;
                hit_q        <= 1'b0;
                err_q        <= 1'b0;
            end
            if (rsp_take && !req_hs) begin
                done_q <= 1'b1;
                hit_q  <= tbl_rsp_hit;
                err_q  <= tbl_rsp_err;
                if (tbl_req_op == OP_LOOKUP && tbl_rsp_hit) result_reg <= tbl_rsp_data;
            end
        end
    end
endmodule
